// File: rtl/reset_recovery_mc.sv
// Multi-channel reset recovery: each switch input is synchronized, debounced and
// stretched into a fixed-length active-low reset, with a power-on stretch and sticky cause bits.
module reset_recovery_mc #(
  parameter int N_CH            = 4,
  parameter int HOLD_CYCLES     = 1000000,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int RETRIGGER       = 0
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [N_CH-1:0] PCB_RST,
  input  logic            clear_cause,
  output logic [N_CH-1:0] reset,
  output logic            chip_reset,
  output logic [N_CH-1:0] cause
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // Loading HOLD_CYCLES-1 and leaving HOLD on the zero count gives exactly HOLD_CYCLES low cycles.
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic [DW-1:0]          db_cnt;
    logic                   d;
    logic                   d_prev;
    logic                   press;
    state_t                 state;
    logic [HW-1:0]          hold_cnt;
    logic                   rst_q;
    logic                   cause_q;

    assign press = d & ~d_prev;

    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        sync_q <= '0;
        db_cnt <= '0;
        d      <= 1'b0;
        d_prev <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], PCB_RST[i]};
        d_prev <= d;
        if (sync_q[SYNC_STAGES-1] == d) begin
          db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
          d      <= ~d;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end
      end
    end

    // Reset lands in HOLD so every channel gets the power-on stretch; a set of cause beats a clear.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        state    <= HOLD;
        hold_cnt <= HOLD_LOAD;
        rst_q    <= 1'b0;
        cause_q  <= 1'b0;
      end else begin
        if (clear_cause) begin
          cause_q <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (press) begin
              state    <= HOLD;
              hold_cnt <= HOLD_LOAD;
              rst_q    <= 1'b0;
              cause_q  <= 1'b1;
            end
          end
          HOLD: begin
            if (press && (RETRIGGER != 0)) begin
              hold_cnt <= HOLD_LOAD;
              cause_q  <= 1'b1;
            end else if (hold_cnt == '0) begin
              state <= IDLE;
              rst_q <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - HW'(1);
            end
          end
          default: begin
            state <= IDLE;
            rst_q <= 1'b1;
          end
        endcase
      end
    end

    assign reset[i] = rst_q;
    assign cause[i] = cause_q;
  end

  assign chip_reset = &reset;

endmodule
